// File: rtl/mc_sequencer_if.sv
// Request/acknowledge channel to the shared instruction+data memory.
interface mc_sequencer_if;
   logic mem_req;
   logic mem_we;
   logic iord;
   logic mem_ack;

   modport master (
      output mem_req,
      output mem_we,
      output iord,
      input  mem_ack
   );

   modport slave (
      input  mem_req,
      input  mem_we,
      input  iord,
      output mem_ack
   );
endinterface

// File: rtl/mc_sequencer.sv
// Multi-cycle FETCH/DECODE/EXEC/MEM/WB control FSM for the MIPS-subset datapath.
// Define PERF_CNT_EN to add the retired-instruction counter output.
module mc_sequencer #(
   parameter int ACK_TIMEOUT = 255,
   parameter int CNT_W       = 32
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [5:0]       opcode,
   input  logic [5:0]       funct,
   input  logic             zero,
   mc_sequencer_if.master   mem,
   output logic             ir_we,
   output logic             pc_we,
   output logic [1:0]       pc_src,
   output logic             reg_we,
   output logic [1:0]       reg_dst,
   output logic [1:0]       wb_src,
   output logic             alu_src_b,
   output logic [2:0]       alu_cntrl,
`ifdef PERF_CNT_EN
   output logic [CNT_W-1:0] retired,
`endif
   output logic             illegal
);

   localparam logic [2:0] FETCH  = 3'd0;
   localparam logic [2:0] DECODE = 3'd1;
   localparam logic [2:0] EXEC   = 3'd2;
   localparam logic [2:0] MEM    = 3'd3;
   localparam logic [2:0] WB     = 3'd4;
   localparam logic [2:0] TRAP   = 3'd5;

   localparam logic [5:0] OP_R    = 6'h00;
   localparam logic [5:0] OP_J    = 6'h02;
   localparam logic [5:0] OP_JAL  = 6'h03;
   localparam logic [5:0] OP_BNE  = 6'h05;
   localparam logic [5:0] OP_XORI = 6'h0E;
   localparam logic [5:0] OP_LW   = 6'h23;
   localparam logic [5:0] OP_SW   = 6'h2B;

   localparam logic [5:0] FN_JR  = 6'h08;
   localparam logic [5:0] FN_ADD = 6'h20;
   localparam logic [5:0] FN_SUB = 6'h22;
   localparam logic [5:0] FN_SLT = 6'h2A;

   localparam logic [2:0] ALU_ADD = 3'd0;
   localparam logic [2:0] ALU_SUB = 3'd1;
   localparam logic [2:0] ALU_XOR = 3'd2;
   localparam logic [2:0] ALU_SLT = 3'd3;

   localparam logic [1:0] PC_SEQ = 2'd0;
   localparam logic [1:0] PC_BR  = 2'd1;
   localparam logic [1:0] PC_JMP = 2'd2;
   localparam logic [1:0] PC_REG = 2'd3;

   localparam logic [1:0] DST_RT = 2'd0;
   localparam logic [1:0] DST_RD = 2'd1;
   localparam logic [1:0] DST_RA = 2'd2;

   localparam logic [1:0] WB_ALU = 2'd0;
   localparam logic [1:0] WB_MEM = 2'd1;
   localparam logic [1:0] WB_PC4 = 2'd2;

   localparam int TW = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT + 1) : 1;
   localparam logic [TW-1:0] LIMIT =
      (ACK_TIMEOUT > 0) ? TW'(ACK_TIMEOUT - 1) : '0;

   logic [2:0]    state;
   logic [2:0]    nextState;
   logic          run;
   logic [TW-1:0] waitCnt;
   logic          waiting;
   logic          timeout;
   logic [5:0]    opReg;
   logic [5:0]    fnReg;
   logic          legal;
   logic          retireNow;

   logic isR;
   logic isAdd;
   logic isSub;
   logic isSlt;
   logic isJr;
   logic isAlu;
   logic isLw;
   logic isSw;
   logic isBne;
   logic isXori;
   logic isJ;
   logic isJal;

   assign isR    = (opReg == OP_R);
   assign isAdd  = isR && (fnReg == FN_ADD);
   assign isSub  = isR && (fnReg == FN_SUB);
   assign isSlt  = isR && (fnReg == FN_SLT);
   assign isJr   = isR && (fnReg == FN_JR);
   assign isAlu  = isAdd || isSub || isSlt;
   assign isLw   = (opReg == OP_LW);
   assign isSw   = (opReg == OP_SW);
   assign isBne  = (opReg == OP_BNE);
   assign isXori = (opReg == OP_XORI);
   assign isJ    = (opReg == OP_J);
   assign isJal  = (opReg == OP_JAL);

   // run holds strobes low until the first edge after reset releases
   assign waiting = run && ((state == FETCH) || (state == MEM));
   assign timeout = (ACK_TIMEOUT > 0) && (waitCnt == LIMIT);

   always_comb begin
      legal = 1'b0;
      case (opcode)
         OP_R: legal = (funct == FN_ADD) || (funct == FN_SUB) ||
                       (funct == FN_SLT) || (funct == FN_JR);
         OP_LW, OP_SW, OP_BNE, OP_XORI, OP_J, OP_JAL: legal = 1'b1;
         default: legal = 1'b0;
      endcase
   end

   always_comb begin
      nextState = state;
      unique case (state)
         FETCH: begin
            if (run) begin
               if (mem.mem_ack)  nextState = DECODE;
               else if (timeout) nextState = TRAP;
            end
         end
         DECODE: nextState = legal ? EXEC : TRAP;
         EXEC: begin
            if (isLw || isSw)          nextState = MEM;
            else if (isAlu || isXori) nextState = WB;
            else                      nextState = FETCH;
         end
         MEM: begin
            if (mem.mem_ack)  nextState = isSw ? FETCH : WB;
            else if (timeout) nextState = TRAP;
         end
         WB:      nextState = FETCH;
         TRAP:    nextState = TRAP;
         default: nextState = TRAP;
      endcase
   end

   assign retireNow = (nextState == FETCH) &&
                      ((state == EXEC) || (state == MEM) || (state == WB));

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state   <= FETCH;
         run     <= 1'b0;
         waitCnt <= '0;
         opReg   <= '0;
         fnReg   <= '0;
      end else begin
         run   <= 1'b1;
         state <= nextState;
         if (state == DECODE) begin
            opReg <= opcode;
            fnReg <= funct;
         end
         if (waiting && !mem.mem_ack && (ACK_TIMEOUT > 0))
            waitCnt <= waitCnt + TW'(1);
         else
            waitCnt <= '0;
      end
   end

`ifdef PERF_CNT_EN
   always_ff @(posedge clk or posedge reset) begin
      if (reset)          retired <= '0;
      else if (retireNow) retired <= retired + CNT_W'(1);
   end
`else
   logic unusedCfg;
   assign unusedCfg = retireNow ^ (|CNT_W);
`endif

   always_comb begin
      mem.mem_req = 1'b0;
      mem.mem_we  = 1'b0;
      mem.iord    = 1'b0;
      ir_we       = 1'b0;
      pc_we       = 1'b0;
      pc_src      = PC_SEQ;
      reg_we      = 1'b0;
      reg_dst     = DST_RT;
      wb_src      = WB_ALU;
      alu_src_b   = 1'b0;
      alu_cntrl   = ALU_ADD;
      illegal     = 1'b0;
      unique case (state)
         FETCH: begin
            if (run) begin
               mem.mem_req = 1'b1;
               if (mem.mem_ack) begin
                  ir_we = 1'b1;
                  pc_we = 1'b1;
               end
            end
         end
         DECODE: ;
         EXEC: begin
            unique case (1'b1)
               isAdd: alu_cntrl = ALU_ADD;
               isSub: alu_cntrl = ALU_SUB;
               isSlt: alu_cntrl = ALU_SLT;
               isXori: begin
                  alu_src_b = 1'b1;
                  alu_cntrl = ALU_XOR;
               end
               isLw, isSw: begin
                  alu_src_b = 1'b1;
                  alu_cntrl = ALU_ADD;
               end
               isBne: begin
                  alu_cntrl = ALU_SUB;
                  pc_we     = !zero;
                  pc_src    = PC_BR;
               end
               isJ: begin
                  pc_we  = 1'b1;
                  pc_src = PC_JMP;
               end
               isJr: begin
                  pc_we  = 1'b1;
                  pc_src = PC_REG;
               end
               isJal: begin
                  pc_we   = 1'b1;
                  pc_src  = PC_JMP;
                  reg_we  = 1'b1;
                  reg_dst = DST_RA;
                  wb_src  = WB_PC4;
               end
               default: ;
            endcase
         end
         MEM: begin
            mem.mem_req = 1'b1;
            mem.iord    = 1'b1;
            mem.mem_we  = isSw;
         end
         WB: begin
            reg_we = 1'b1;
            unique case (1'b1)
               isAlu:   reg_dst = DST_RD;
               isLw:    wb_src  = WB_MEM;
               default: ;
            endcase
         end
         TRAP:    illegal = 1'b1;
         default: illegal = 1'b1;
      endcase
   end

endmodule

// File: tb/tb_mc_sequencer.sv
// Scoreboard bench for mc_sequencer: per-cycle expected control words.
module tb_mc_sequencer;

   typedef logic [16:0] ctl_t;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic [5:0] opcode = '0;
   logic [5:0] funct = '0;
   logic       zero = 1'b0;
   logic       ir_we;
   logic       pc_we;
   logic [1:0] pc_src;
   logic       reg_we;
   logic [1:0] reg_dst;
   logic [1:0] wb_src;
   logic       alu_src_b;
   logic [2:0] alu_cntrl;
   logic       illegal;
`ifdef PERF_CNT_EN
   logic [31:0] retired;
`endif

   int tests = 0;
   int failed = 0;

   ctl_t       sb[$];
   logic [13:0] stim[$];
   logic [5:0] curOp = '0;
   logic [5:0] curFn = '0;

   mc_sequencer_if bus ();

   mc_sequencer #(.ACK_TIMEOUT(4)) dut (
      .clk       (clk),
      .reset     (reset),
      .opcode    (opcode),
      .funct     (funct),
      .zero      (zero),
      .mem       (bus.master),
      .ir_we     (ir_we),
      .pc_we     (pc_we),
      .pc_src    (pc_src),
      .reg_we    (reg_we),
      .reg_dst   (reg_dst),
      .wb_src    (wb_src),
      .alu_src_b (alu_src_b),
      .alu_cntrl (alu_cntrl),
`ifdef PERF_CNT_EN
      .retired   (retired),
`endif
      .illegal   (illegal)
   );

   always #5 clk = ~clk;

   function automatic ctl_t mk(
      input logic rq, input logic we, input logic io,
      input logic ir, input logic pw, input logic [1:0] ps,
      input logic rw, input logic [1:0] rd, input logic [1:0] wb,
      input logic as, input logic [2:0] al, input logic il);
      return {rq, we, io, ir, pw, ps, rw, rd, wb, as, al, il};
   endfunction

   function automatic ctl_t observe();
      return {bus.mem_req, bus.mem_we, bus.iord, ir_we, pc_we, pc_src,
              reg_we, reg_dst, wb_src, alu_src_b, alu_cntrl, illegal};
   endfunction

   ctl_t W_IDLE, W_FWAIT, W_FACK, W_TRAP;

   task automatic push(input logic a, input logic z, input ctl_t e);
      stim.push_back({a, z, curOp, curFn});
      sb.push_back(e);
   endtask

   task automatic do_reset();
      reset = 1'b1;
      bus.mem_ack = 1'b0;
      @(posedge clk); #1;
      reset = 1'b0;
      @(posedge clk); #1;
   endtask

   task automatic test_reset();
      ctl_t obs, exp;
      @(posedge clk); #1;
      push(1'b0, 1'b0, W_IDLE);
      exp = sb.pop_front(); void'(stim.pop_front());
      obs = observe(); tests++;
      if (obs !== exp) begin
         failed++;
         $display("FAIL reset_hold got %h want %h", obs, exp);
      end
      @(posedge clk); #1;
      reset = 1'b0; #1;
      push(1'b0, 1'b0, W_IDLE);
      exp = sb.pop_front(); void'(stim.pop_front());
      obs = observe(); tests++;
      if (obs !== exp) begin
         failed++;
         $display("FAIL reset_release got %h want %h", obs, exp);
      end
      @(posedge clk); #1;
      push(1'b0, 1'b0, W_FWAIT);
      exp = sb.pop_front(); void'(stim.pop_front());
      obs = observe(); tests++;
      if (obs !== exp) begin
         failed++;
         $display("FAIL first_fetch got %h want %h", obs, exp);
      end
      reset = 1'b1; #1;
      push(1'b0, 1'b0, W_IDLE);
      exp = sb.pop_front(); void'(stim.pop_front());
      obs = observe(); tests++;
      if (obs !== exp) begin
         failed++;
         $display("FAIL reset_mid_fetch got %h want %h", obs, exp);
      end
      @(posedge clk); #1;
      reset = 1'b0;
      @(posedge clk); #1;
      push(1'b0, 1'b0, W_FWAIT);
      exp = sb.pop_front(); void'(stim.pop_front());
      obs = observe(); tests++;
      if (obs !== exp) begin
         failed++;
         $display("FAIL fetch_after_release got %h want %h", obs, exp);
      end
`ifdef PERF_CNT_EN
      tests++;
      if (retired !== 32'd0) begin
         failed++;
         $display("FAIL retired_reset got %0d want 0", retired);
      end
`endif
   endtask

   task automatic test_alu();
      ctl_t obs, exp;
      logic [13:0] s;
      int n = 0;
      curOp = 6'h00; curFn = 6'h20;
      push(1, 0, W_FACK); push(0, 0, W_IDLE);
      push(0, 0, mk(0,0,0,0,0,0,0,0,0,0,3'd0,0));
      push(0, 0, mk(0,0,0,0,0,0,1,2'd1,2'd0,0,0,0));
      curOp = 6'h00; curFn = 6'h22;
      push(1, 0, W_FACK); push(0, 0, W_IDLE);
      push(0, 0, mk(0,0,0,0,0,0,0,0,0,0,3'd1,0));
      push(0, 0, mk(0,0,0,0,0,0,1,2'd1,2'd0,0,0,0));
      curOp = 6'h00; curFn = 6'h2A;
      push(1, 0, W_FACK); push(0, 0, W_IDLE);
      push(0, 0, mk(0,0,0,0,0,0,0,0,0,0,3'd3,0));
      push(0, 0, mk(0,0,0,0,0,0,1,2'd1,2'd0,0,0,0));
      curOp = 6'h0E; curFn = 6'h3F;
      push(1, 0, W_FACK); push(0, 0, W_IDLE);
      push(0, 0, mk(0,0,0,0,0,0,0,0,0,1,3'd2,0));
      push(0, 0, mk(0,0,0,0,0,0,1,2'd0,2'd0,0,0,0));
      while (sb.size() != 0) begin
         s = stim.pop_front();
         bus.mem_ack = s[13]; zero = s[12];
         opcode = s[11:6]; funct = s[5:0];
         #1;
         exp = sb.pop_front(); obs = observe(); tests++;
         if (obs !== exp) begin
            failed++;
            $display("FAIL alu cyc%0d got %h want %h", n, obs, exp);
         end
         n++;
         @(posedge clk); #1;
      end
      bus.mem_ack = 1'b0;
   endtask

   task automatic test_lw();
      ctl_t obs, exp;
      logic [13:0] s;
      int n = 0;
      ctl_t wmem;
      wmem = mk(1,0,1,0,0,0,0,0,0,0,0,0);
      curOp = 6'h23; curFn = 6'h00;
      push(1, 0, W_FACK); push(0, 0, W_IDLE);
      push(0, 0, mk(0,0,0,0,0,0,0,0,0,1,3'd0,0));
      push(0, 0, wmem); push(0, 0, wmem); push(0, 0, wmem);
      push(1, 0, wmem);
      push(0, 0, mk(0,0,0,0,0,0,1,2'd0,2'd1,0,0,0));
      while (sb.size() != 0) begin
         s = stim.pop_front();
         bus.mem_ack = s[13]; zero = s[12];
         opcode = s[11:6]; funct = s[5:0];
         #1;
         exp = sb.pop_front(); obs = observe(); tests++;
         if (obs !== exp) begin
            failed++;
            $display("FAIL lw cyc%0d got %h want %h", n, obs, exp);
         end
         n++;
         @(posedge clk); #1;
      end
      bus.mem_ack = 1'b0;
   endtask

   task automatic test_bne();
      ctl_t obs, exp;
      logic [13:0] s;
      int n = 0;
      curOp = 6'h05; curFn = 6'h00;
      push(1, 0, W_FACK); push(0, 0, W_IDLE);
      push(0, 1, mk(0,0,0,0,0,2'd1,0,0,0,0,3'd1,0));
      push(1, 0, W_FACK); push(0, 0, W_IDLE);
      push(0, 0, mk(0,0,0,0,1,2'd1,0,0,0,0,3'd1,0));
      push(0, 0, W_FWAIT);
      while (sb.size() != 0) begin
         s = stim.pop_front();
         bus.mem_ack = s[13]; zero = s[12];
         opcode = s[11:6]; funct = s[5:0];
         #1;
         exp = sb.pop_front(); obs = observe(); tests++;
         if (obs !== exp) begin
            failed++;
            $display("FAIL bne cyc%0d got %h want %h", n, obs, exp);
         end
         n++;
         @(posedge clk); #1;
      end
      bus.mem_ack = 1'b0;
      zero = 1'b0;
   endtask

   task automatic test_jump_trap();
      ctl_t obs, exp;
      logic [13:0] s;
      int n = 0;
      curOp = 6'h02; curFn = 6'h00;
      push(1, 0, W_FACK); push(0, 0, W_IDLE);
      push(0, 0, mk(0,0,0,0,1,2'd2,0,0,0,0,0,0));
      curOp = 6'h00; curFn = 6'h08;
      push(1, 0, W_FACK); push(0, 0, W_IDLE);
      push(0, 0, mk(0,0,0,0,1,2'd3,0,0,0,0,0,0));
      curOp = 6'h03; curFn = 6'h00;
      push(1, 0, W_FACK); push(0, 0, W_IDLE);
      push(0, 0, mk(0,0,0,0,1,2'd2,1,2'd2,2'd2,0,0,0));
      curOp = 6'h3F; curFn = 6'h00;
      push(1, 0, W_FACK); push(0, 0, W_IDLE);
      push(0, 0, W_TRAP); push(1, 0, W_TRAP);
      while (sb.size() != 0) begin
         s = stim.pop_front();
         bus.mem_ack = s[13]; zero = s[12];
         opcode = s[11:6]; funct = s[5:0];
         #1;
         exp = sb.pop_front(); obs = observe(); tests++;
         if (obs !== exp) begin
            failed++;
            $display("FAIL jump_trap cyc%0d got %h want %h", n, obs, exp);
         end
         n++;
         @(posedge clk); #1;
      end
      do_reset();
      curOp = 6'h00; curFn = 6'h21;
      push(1, 0, W_FACK); push(0, 0, W_IDLE);
      push(0, 0, W_TRAP);
      n = 0;
      while (sb.size() != 0) begin
         s = stim.pop_front();
         bus.mem_ack = s[13]; zero = s[12];
         opcode = s[11:6]; funct = s[5:0];
         #1;
         exp = sb.pop_front(); obs = observe(); tests++;
         if (obs !== exp) begin
            failed++;
            $display("FAIL bad_funct cyc%0d got %h want %h", n, obs, exp);
         end
         n++;
         @(posedge clk); #1;
      end
      do_reset();
   endtask

   task automatic test_timeout();
      ctl_t obs, exp;
      logic [13:0] s;
      int n = 0;
      do_reset();
      curOp = 6'h02; curFn = 6'h00;
      push(0, 0, W_FWAIT); push(0, 0, W_FWAIT);
      push(0, 0, W_FWAIT); push(0, 0, W_FWAIT);
      push(0, 0, W_TRAP); push(1, 0, W_TRAP);
      while (sb.size() != 0) begin
         s = stim.pop_front();
         bus.mem_ack = s[13]; zero = s[12];
         opcode = s[11:6]; funct = s[5:0];
         #1;
         exp = sb.pop_front(); obs = observe(); tests++;
         if (obs !== exp) begin
            failed++;
            $display("FAIL timeout cyc%0d got %h want %h", n, obs, exp);
         end
         n++;
         @(posedge clk); #1;
      end
      do_reset();
   endtask

   task automatic test_back_to_back();
      ctl_t obs, exp;
      logic [13:0] s;
      int n = 0;
      do_reset();
      curOp = 6'h02; curFn = 6'h00;
      push(1, 0, W_FACK); push(0, 0, W_IDLE);
      push(0, 0, mk(0,0,0,0,1,2'd2,0,0,0,0,0,0));
      curOp = 6'h00; curFn = 6'h20;
      push(1, 0, W_FACK); push(0, 0, W_IDLE);
      push(0, 0, mk(0,0,0,0,0,0,0,0,0,0,3'd0,0));
      push(0, 0, mk(0,0,0,0,0,0,1,2'd1,2'd0,0,0,0));
      curOp = 6'h2B; curFn = 6'h00;
      push(1, 0, W_FACK); push(0, 0, W_IDLE);
      push(0, 0, mk(0,0,0,0,0,0,0,0,0,1,3'd0,0));
      push(1, 0, mk(1,1,1,0,0,0,0,0,0,0,0,0));
      push(0, 0, W_FWAIT);
      while (sb.size() != 0) begin
         s = stim.pop_front();
         bus.mem_ack = s[13]; zero = s[12];
         opcode = s[11:6]; funct = s[5:0];
         #1;
         exp = sb.pop_front(); obs = observe(); tests++;
         if (obs !== exp) begin
            failed++;
            $display("FAIL b2b cyc%0d got %h want %h", n, obs, exp);
         end
         n++;
         @(posedge clk); #1;
      end
      bus.mem_ack = 1'b0;
`ifdef PERF_CNT_EN
      tests++;
      if (retired !== 32'd3) begin
         failed++;
         $display("FAIL retired_count got %0d want 3", retired);
      end
`endif
   endtask

   initial begin
      bus.mem_ack = 1'b0;
      W_IDLE  = '0;
      W_FWAIT = mk(1,0,0,0,0,0,0,0,0,0,0,0);
      W_FACK  = mk(1,0,0,1,1,2'd0,0,0,0,0,0,0);
      W_TRAP  = mk(0,0,0,0,0,0,0,0,0,0,0,1);
      test_reset();
      test_alu();
      test_lw();
      test_bne();
      test_jump_trap();
      test_timeout();
      test_back_to_back();
      $display("[TB] %0d tests run, %0d failed", tests, failed);
      $finish;
   end

endmodule
